// File: rtl/countdown_timer_pkg.sv
// Shared types and BCD helpers for the countdown timer controller.
// States, field limits, sw clamping and single-field decrement-with-borrow.
package countdown_timer_pkg;

   typedef enum logic [2:0] {IDLE, SET, RUN, PAUSE, ALARM} state_t;

   localparam logic [7:0] FIELD_MAX_LOW = 8'h59;
   localparam logic [7:0] FIELD_MAX_TOP = 8'h99;

   // Clamp a raw {tens, units} switch value to a valid field value.
   function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic top);
      logic [3:0] tens_max;
      logic [3:0] tens;
      logic [3:0] units;
      tens_max = top ? FIELD_MAX_TOP[7:4] : FIELD_MAX_LOW[7:4];
      tens     = (v[7:4] > tens_max) ? tens_max : v[7:4];
      units    = (v[3:0] > FIELD_MAX_TOP[3:0]) ? FIELD_MAX_TOP[3:0] : v[3:0];
      return {tens, units};
   endfunction

   // Decrement one field; a field at 00 wraps to 59 (caller propagates the borrow).
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v == '0)
         return FIELD_MAX_LOW;
      if (v[3:0] == '0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// One-second tick prescaler and alarm flash divider for countdown_timer_ctrl.
// Each counter is held at zero while its enable is low, so it restarts on enable.
module tick_gen #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned FLASH_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   input  logic flash_en,
   output logic tick,
   output logic flash_toggle
);

   localparam int unsigned W = $clog2(CLK_HZ);
   localparam logic [W-1:0] TICK_LAST  = W'(CLK_HZ - 1);
   localparam logic [W-1:0] FLASH_LAST = W'(CLK_HZ / FLASH_DIV - 1);

   logic [W-1:0] tick_cnt;
   logic [W-1:0] flash_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt  <= '0;
         flash_cnt <= '0;
      end else begin
         if (!tick_en || tick_cnt == TICK_LAST)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + W'(1);
         if (!flash_en || flash_cnt == FLASH_LAST)
            flash_cnt <= '0;
         else
            flash_cnt <= flash_cnt + W'(1);
      end
   end

   assign tick         = tick_en && (tick_cnt == TICK_LAST);
   assign flash_toggle = flash_en && (flash_cnt == FLASH_LAST);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Multi-field BCD countdown timer controller: set/run/pause/alarm FSM.
// Optional TIMER_AUTO_RELOAD_EN restores the last set time when leaving ALARM.
module countdown_timer_ctrl
   import countdown_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned FIELDS    = 2,
   parameter int unsigned FLASH_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_p,
   input  logic                  start_stop_p,
   input  logic [7:0]            sw,
   output logic [8*FIELDS-1:0]   time_bcd,
   output logic [1:0]            edit_field,
   output logic                  running,
   output logic                  alarm,
   output logic                  flash
);

   localparam logic [1:0] TOP_FIELD = 2'(FIELDS - 1);

   state_t              state;
   logic [8*FIELDS-1:0] fields;
   logic [8*FIELDS-1:0] dec_time;
   logic [8*FIELDS-1:0] committed;
   logic [8*FIELDS-1:0] preview_next;
   logic                dec_zero;
   logic                borrow;
   logic                edit_is_top;
   logic [1:0]          edit_next;
   logic [7:0]          cur_clamp;
   logic [7:0]          nxt_clamp;
   logic                tick;
   logic                flash_toggle;
`ifdef TIMER_AUTO_RELOAD_EN
   logic [8*FIELDS-1:0] reload;
`endif

   tick_gen #(
      .CLK_HZ   (CLK_HZ),
      .FLASH_DIV(FLASH_DIV)
   ) u_tick_gen (
      .clk         (clk),
      .rst         (reset),
      .tick_en     (state == RUN),
      .flash_en    (state == ALARM),
      .tick        (tick),
      .flash_toggle(flash_toggle)
   );

   always_comb begin
      borrow   = 1'b1;
      dec_time = fields;
      for (int unsigned i = 0; i < FIELDS; i++) begin
         if (borrow)
            dec_time[8*i +: 8] = bcd_dec(fields[8*i +: 8]);
         borrow = borrow && (fields[8*i +: 8] == '0);
      end
      dec_zero = (dec_time == '0);

      // committed: fields with the edited field replaced by live sw; also the SET preview.
      edit_is_top  = (edit_field == TOP_FIELD);
      edit_next    = edit_field + 2'd1;
      cur_clamp    = bcd_clamp(sw, edit_is_top);
      nxt_clamp    = bcd_clamp(sw, edit_next == TOP_FIELD);
      committed    = fields;
      for (int unsigned i = 0; i < FIELDS; i++)
         if (2'(i) == edit_field)
            committed[8*i +: 8] = cur_clamp;
      preview_next = committed;
      for (int unsigned i = 0; i < FIELDS; i++)
         if (2'(i) == edit_next)
            preview_next[8*i +: 8] = nxt_clamp;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fields     <= '0;
         time_bcd   <= '0;
         edit_field <= '0;
         running    <= 1'b0;
         alarm      <= 1'b0;
         flash      <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
         reload     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_stop_p) begin
                  if (fields != '0) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end else if (set_p) begin
                  state      <= SET;
                  edit_field <= '0;
                  time_bcd   <= committed;
               end
            end
            SET: begin
               if (set_p) begin
                  fields <= committed;
`ifdef TIMER_AUTO_RELOAD_EN
                  reload <= committed;
`endif
                  if (edit_is_top) begin
                     state      <= IDLE;
                     edit_field <= '0;
                     time_bcd   <= committed;
                  end else begin
                     edit_field <= edit_next;
                     time_bcd   <= preview_next;
                  end
               end else begin
                  time_bcd <= committed;
               end
            end
            RUN: begin
               if (start_stop_p) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (tick) begin
                  fields   <= dec_time;
                  time_bcd <= dec_time;
                  if (dec_zero) begin
                     state   <= ALARM;
                     running <= 1'b0;
                     alarm   <= 1'b1;
                     flash   <= 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (start_stop_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else if (set_p) begin
                  state <= IDLE;
               end
            end
            ALARM: begin
               if (set_p || start_stop_p) begin
                  state <= IDLE;
                  alarm <= 1'b0;
                  flash <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
                  fields   <= reload;
                  time_bcd <= reload;
`endif
               end else if (flash_toggle) begin
                  flash <= ~flash;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl (CLK_HZ=8, FLASH_DIV=2, FIELDS=2).
module tb_countdown_timer_ctrl;

   localparam int unsigned CLK_HZ    = 8;
   localparam int unsigned FIELDS    = 2;
   localparam int unsigned FLASH_DIV = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        set_p = 1'b0;
   logic        start_stop_p = 1'b0;
   logic [7:0]  sw = '0;
   logic [15:0] time_bcd;
   logic [1:0]  edit_field;
   logic        running;
   logic        alarm;
   logic        flash;

   int checks = 0;
   int failures = 0;

   countdown_timer_ctrl #(
      .CLK_HZ   (CLK_HZ),
      .FIELDS   (FIELDS),
      .FLASH_DIV(FLASH_DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .set_p       (set_p),
      .start_stop_p(start_stop_p),
      .sw          (sw),
      .time_bcd    (time_bcd),
      .edit_field  (edit_field),
      .running     (running),
      .alarm       (alarm),
      .flash       (flash)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic s, input logic ss);
      @(negedge clk);
      set_p        = s;
      start_stop_p = ss;
      @(negedge clk);
      set_p        = 1'b0;
      start_stop_p = 1'b0;
   endtask

   task automatic load(input logic [15:0] t);
      sw = t[7:0];
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      sw = t[15:8];
      pulse(1'b1, 1'b0);
   endtask

   initial begin
      // Reset state
      cycles(2);
      reset = 1'b0;
      cycles(1);
      check("rst_time", 32'(time_bcd), 32'h0);
      check("rst_edit", 32'(edit_field), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_alarm", 32'(alarm), 32'h0);
      check("rst_flash", 32'(flash), 32'h0);

      // Start with zero time stays idle
      pulse(1'b0, 1'b1);
      check("zero_start_running", 32'(running), 32'h0);
      check("zero_start_time", 32'(time_bcd), 32'h0);

      // Set entry with clamping and live preview
      sw = 8'h7A;
      pulse(1'b1, 1'b0);
      check("set_enter_edit", 32'(edit_field), 32'h0);
      check("set_enter_preview", 32'(time_bcd), 32'h0059);
      pulse(1'b1, 1'b0);
      check("set_f0_edit", 32'(edit_field), 32'h1);
      check("set_f0_commit", 32'(time_bcd), 32'h7959);
      sw = 8'h12;
      check("preview_latency_old", 32'(time_bcd), 32'h7959);
      cycles(1);
      check("preview_latency_new", 32'(time_bcd), 32'h1259);
      pulse(1'b0, 1'b1);
      check("set_ignores_ss_edit", 32'(edit_field), 32'h1);
      check("set_ignores_ss_run", 32'(running), 32'h0);
      pulse(1'b1, 1'b0);
      check("set_done_time", 32'(time_bcd), 32'h1259);
      check("set_done_edit", 32'(edit_field), 32'h0);
      check("set_done_running", 32'(running), 32'h0);

      // Simultaneous keys in IDLE: start_stop wins; first tick timing; alarm and flash
      load(16'h0003);
      check("load3_time", 32'(time_bcd), 32'h0003);
      pulse(1'b1, 1'b1);
      check("prio_running", 32'(running), 32'h1);
      check("prio_edit", 32'(edit_field), 32'h0);
      cycles(7);
      check("tick_not_yet", 32'(time_bcd), 32'h0003);
      cycles(1);
      check("tick_first", 32'(time_bcd), 32'h0002);
      cycles(16);
      check("alarm_time", 32'(time_bcd), 32'h0000);
      check("alarm_flag", 32'(alarm), 32'h1);
      check("alarm_flash_entry", 32'(flash), 32'h1);
      check("alarm_running", 32'(running), 32'h0);
      cycles(3);
      check("flash_hold", 32'(flash), 32'h1);
      cycles(1);
      check("flash_toggle1", 32'(flash), 32'h0);
      cycles(4);
      check("flash_toggle2", 32'(flash), 32'h1);
      pulse(1'b1, 1'b0);
      check("alarm_exit_alarm", 32'(alarm), 32'h0);
      check("alarm_exit_flash", 32'(flash), 32'h0);
`ifdef TIMER_AUTO_RELOAD_EN
      check("alarm_exit_time", 32'(time_bcd), 32'h0003);
`else
      check("alarm_exit_time", 32'(time_bcd), 32'h0000);
`endif

      // Borrow across fields and run-down to alarm
      load(16'h0100);
      pulse(1'b0, 1'b1);
      check("borrow_running", 32'(running), 32'h1);
      cycles(8);
      check("borrow_0059", 32'(time_bcd), 32'h0059);
      cycles(8 * 59 - 1);
      check("borrow_0001", 32'(time_bcd), 32'h0001);
      check("borrow_no_alarm", 32'(alarm), 32'h0);
      cycles(1);
      check("borrow_zero", 32'(time_bcd), 32'h0000);
      check("borrow_alarm", 32'(alarm), 32'h1);
      check("borrow_flash", 32'(flash), 32'h1);
      cycles(4);
      check("borrow_flash_toggle", 32'(flash), 32'h0);
      pulse(1'b0, 1'b1);
      check("borrow_exit_alarm", 32'(alarm), 32'h0);
`ifdef TIMER_AUTO_RELOAD_EN
      check("borrow_exit_time", 32'(time_bcd), 32'h0100);
`else
      check("borrow_exit_time", 32'(time_bcd), 32'h0000);
`endif

      // Pause discards the partial second
      load(16'h0005);
      pulse(1'b0, 1'b1);
      cycles(3);
      pulse(1'b0, 1'b1);
      check("pause_running", 32'(running), 32'h0);
      check("pause_time", 32'(time_bcd), 32'h0005);
      cycles(10);
      check("pause_hold", 32'(time_bcd), 32'h0005);
      pulse(1'b0, 1'b1);
      check("resume_running", 32'(running), 32'h1);
      cycles(7);
      check("resume_not_yet", 32'(time_bcd), 32'h0005);
      cycles(1);
      check("resume_tick", 32'(time_bcd), 32'h0004);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      check("pause_set_idle_time", 32'(time_bcd), 32'h0004);
      check("pause_set_idle_run", 32'(running), 32'h0);
      pulse(1'b0, 1'b1);
      check("idle_restart", 32'(running), 32'h1);

      // Asynchronous reset mid-run
      load(16'h0130);
      @(negedge clk);
      check("rst_mid_running_pre", 32'(running), 32'h1);
      cycles(3);
      reset = 1'b1;
      #1;
      check("rst_mid_time", 32'(time_bcd), 32'h0);
      check("rst_mid_running", 32'(running), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      cycles(10);
      check("rst_mid_stays_idle", 32'(time_bcd), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Parametrised multi-field countdown timer controller: the next-generation egg timer core. It holds FIELDS base-60 BCD time fields, for example mm:ss or hh:mm:ss. Field values are loaded from switches under a set/start-stop key protocol, counted down once per second with pause/resume, and an alarm state with a flash strobe is raised at zero. It sits between the debounced key/switch inputs and the seven-segment/LED display logic of the board top level.

## Interface
Parameters:
- CLK_HZ, 50_000_000: clock cycles per one-second tick; must be ≥2.
- FIELDS, 2: number of two-digit BCD fields, 1..4; field 0 is least significant (seconds).
- FLASH_DIV, 4: flash toggles FLASH_DIV times per second in ALARM; CLK_HZ must be divisible by FLASH_DIV.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- set_p  in  1  single-cycle pulse, set key (pre-debounced).
- start_stop_p  in  1  single-cycle pulse, start/stop key (pre-debounced).
- sw  in  8  BCD entry value {tens, units}.
- time_bcd  out  8*FIELDS  displayed time; in a SET state, the field being set shows the clamped sw value live.
- edit_field  out  2  index of the field being set; 0 outside SET.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- flash  out  1  alarm strobe; 0 outside ALARM.

## Operation
- States: IDLE, SET, RUN, PAUSE, ALARM.
- Field clamp: the top field (index FIELDS-1) allows 00..99; the other fields allow 00..59.
  - Any nibble >9 clamps to 9.
  - In a 00..59 field, a tens nibble >5 clamps to 5.
- IDLE:
  - set_p → SET with edit_field=0.
  - start_stop_p → RUN if time≠0; otherwise stay in IDLE.
- SET:
  - set_p commits the clamped sw value into field edit_field.
  - If edit_field=FIELDS-1, go to IDLE; otherwise increment edit_field.
  - start_stop_p is ignored.
- RUN:
  - Each tick decrements time as one mixed-radix number with borrow chaining. A field at 00 that borrows becomes 59.
  - The tick that produces all-zero goes to ALARM on the same edge.
  - start_stop_p → PAUSE. set_p is ignored.
- PAUSE:
  - start_stop_p → RUN.
  - set_p → IDLE; time is kept.
- ALARM:
  - flash toggles every CLK_HZ/FLASH_DIV cycles, starting at 1 on entry.
  - set_p or start_stop_p → IDLE and clears flash.
- Simultaneous set_p and start_stop_p: start_stop_p wins in every state except SET, where set_p acts.
- Tick prescaler:
  - Counts 0..CLK_HZ-1 and is held at 0 outside RUN.
  - It restarts on every entry to RUN, so a pause discards the partial second.

## Timing
- All outputs are registered. Reset values: time_bcd=0, edit_field=0, running=0, alarm=0, flash=0, state=IDLE.
- A pulse sampled at edge N changes state and outputs at edge N; they are visible in cycle N+1.
- First decrement occurs exactly CLK_HZ cycles after the edge that entered RUN; later decrements follow every CLK_HZ cycles.
- alarm rises on the same edge at which time_bcd becomes 0.
- The live sw preview through time_bcd is combinational-to-register: one cycle of latency.
- Reset asserted mid-RUN or mid-ALARM clears all state immediately. Nothing is retained.

## Configuration
- TIMER_AUTO_RELOAD_EN defined:
  - Every commit in SET also writes a reload register.
  - Leaving ALARM reloads time_bcd from that register on the exit edge; the state becomes IDLE.
  - The reload register resets to 0.
- TIMER_AUTO_RELOAD_EN undefined: no reload register; leaving ALARM leaves time_bcd at 0.

## Structure
- Package countdown_timer_pkg holds:
  - the state enum (IDLE, SET, RUN, PAUSE, ALARM);
  - the field max constants (8'h59, 8'h99);
  - a BCD clamp function;
  - a single-field BCD decrement-with-borrow function.
- One sub-module, tick_gen: parametrised prescaler with an enable/clear input, a one-cycle tick output, and a flash-toggle output.
- The controller owns the FSM, field registers, and optional reload register.

## Test plan
All scenarios use CLK_HZ=8, FLASH_DIV=2, FIELDS=2.
- Reset mid-count, with time=01:30 in RUN: assert reset → time_bcd=0, running=0, state IDLE in the same cycle.
- Set entry:
  - set_p; sw=8'h7A; set_p → field0=59.
  - sw=8'h12; set_p → field1=12, state IDLE, time_bcd=16'h1259.
- Borrow and alarm:
  - Load 01:00, then start_stop_p.
  - After 8 cycles, time=00:59.
  - After 60×8 cycles total, time=00:00, alarm=1, flash=1; flash toggles every 4 cycles.
- Pause:
  - Load 00:05, start, pause after 5 cycles, resume.
  - Next decrement comes 8 cycles after resume; time stays 00:05 until then.
- Zero start and priority:
  - start_stop_p with time=0 → stays IDLE.
  - Simultaneous set_p+start_stop_p in IDLE with time=00:03 → RUN.
- TIMER_AUTO_RELOAD_EN: set 00:02, run to ALARM, press set_p → IDLE with time_bcd=16'h0002; without the macro, time_bcd=0.
